// File: rtl/mib_registered_input_demux.sv
// Registered MIB input demux: routes one producer's moves to one of NUM_OUT
// move buffers through a single stage that captures destination with payload.
// Ports:
//   clk, resetn              clock, synchronous active-low reset
//   move_buffer_addr         destination, sampled with in_move_to
//   in_move_to/valid/ack     producer handshake
//   out_move_to/valid/ack    per-buffer handshake, slot i = [i*MOVE_W +: MOVE_W]
//   err_bad_addr, err_addr   sticky bad-address flag and first offending address
//   drop_count               saturating count of dropped moves
//   err_clear                clears the error outputs and drop_count
module mib_registered_input_demux #(
    parameter int NUM_OUT = 8,
    parameter int ADDR_W  = 4,
    parameter int MOVE_W  = 8,
    parameter int CNT_W   = 8
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [ADDR_W-1:0]         move_buffer_addr,
    input  logic [MOVE_W-1:0]         in_move_to,
    input  logic                      in_move_valid,
    output logic                      in_move_ack,
    output logic [NUM_OUT*MOVE_W-1:0] out_move_to,
    output logic [NUM_OUT-1:0]        out_move_valid,
    input  logic [NUM_OUT-1:0]        out_move_ack,
    output logic                      err_bad_addr,
    output logic [ADDR_W-1:0]         err_addr,
    output logic [CNT_W-1:0]          drop_count,
    input  logic                      err_clear
);

    // One extra bit so NUM_OUT == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0]  NUM_OUT_W = (ADDR_W+1)'(NUM_OUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic              stg_valid;
    logic [ADDR_W-1:0] stg_dest;
    logic [MOVE_W-1:0] stg_move;

    logic sel_ack;
    logic dest_ok;
    logic addr_ok;
    logic in_xfer;
    logic out_xfer;
    logic drop;

    // Only the ack of the staged destination matters.
    always_comb begin
        sel_ack = 1'b0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (stg_dest == ADDR_W'(i)) begin
                sel_ack = out_move_ack[i];
            end
        end
    end

    assign dest_ok     = {1'b0, stg_dest} < NUM_OUT_W;
    assign addr_ok     = {1'b0, move_buffer_addr} < NUM_OUT_W;
    assign in_move_ack = !stg_valid || (sel_ack && dest_ok);
    assign in_xfer     = in_move_valid && in_move_ack;
    assign out_xfer    = stg_valid && sel_ack && dest_ok;
    assign drop        = in_xfer && !addr_ok;

    // Payload is decoded from stg_dest alone; unselected slots read zero.
    always_comb begin
        out_move_valid = '0;
        out_move_to    = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (stg_dest == ADDR_W'(i)) begin
                out_move_valid[i]               = stg_valid;
                out_move_to[i*MOVE_W +: MOVE_W] = stg_move;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            stg_valid <= 1'b0;
            stg_dest  <= '0;
            stg_move  <= '0;
        end else if (in_xfer && addr_ok) begin
            stg_valid <= 1'b1;
            stg_dest  <= move_buffer_addr;
            stg_move  <= in_move_to;
        end else if (out_xfer) begin
            stg_valid <= 1'b0;
        end
    end

    // err_clear takes priority over a drop in the same cycle.
    always_ff @(posedge clk) begin
        if (!resetn || err_clear) begin
            err_bad_addr <= 1'b0;
            err_addr     <= '0;
            drop_count   <= '0;
        end else if (drop) begin
            err_bad_addr <= 1'b1;
            if (!err_bad_addr) begin
                err_addr <= move_buffer_addr;
            end
            if (drop_count != CNT_MAX) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mib_registered_input_demux.sv
// Bench for mib_registered_input_demux: directed scenarios then random traffic
// against a queue-based reference model; a CNT_W=2 instance checks saturation.
module tb_mib_registered_input_demux;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  move_buffer_addr;
    logic [7:0]  in_move_to;
    logic        in_move_valid;
    logic [7:0]  out_move_ack;
    logic        err_clear;

    logic        ack1, ack2;
    logic [63:0] to1, to2;
    logic [7:0]  vld1, vld2;
    logic        bad1, bad2;
    logic [3:0]  eaddr1, eaddr2;
    logic [7:0]  cnt1;
    logic [1:0]  cnt2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int dest;
        int mv;
    } ent_t;

    ent_t q[$];
    int   cur_dest;
    int   cur_move;
    bit   m_bad;
    int   m_eaddr;
    int   drops;

    always #5 clk = ~clk;

    mib_registered_input_demux dut1 (
        .clk(clk), .resetn(resetn),
        .move_buffer_addr(move_buffer_addr),
        .in_move_to(in_move_to), .in_move_valid(in_move_valid),
        .in_move_ack(ack1), .out_move_to(to1),
        .out_move_valid(vld1), .out_move_ack(out_move_ack),
        .err_bad_addr(bad1), .err_addr(eaddr1),
        .drop_count(cnt1), .err_clear(err_clear)
    );

    mib_registered_input_demux #(.CNT_W(2)) dut2 (
        .clk(clk), .resetn(resetn),
        .move_buffer_addr(move_buffer_addr),
        .in_move_to(in_move_to), .in_move_valid(in_move_valid),
        .in_move_ack(ack2), .out_move_to(to2),
        .out_move_valid(vld2), .out_move_ack(out_move_ack),
        .err_bad_addr(bad2), .err_addr(eaddr2),
        .drop_count(cnt2), .err_clear(err_clear)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        cur_dest = 0;
        cur_move = 0;
        m_bad    = 0;
        m_eaddr  = 0;
        drops    = 0;
    endtask

    // Drive one cycle, check outputs mid-cycle, advance model at the edge.
    task automatic step(input int addr, input int mv, input bit vld,
                        input logic [7:0] oack, input bit clr);
        logic        e_ack;
        logic [7:0]  e_vld;
        logic [63:0] e_to;
        bit          in_x, out_x;
        int          c8, c2;
        move_buffer_addr = 4'(addr);
        in_move_to       = 8'(mv);
        in_move_valid    = vld;
        out_move_ack     = oack;
        err_clear        = clr;
        #1;
        e_ack = (q.size() == 0) || oack[q[0].dest];
        e_vld = (q.size() != 0) ? (8'd1 << q[0].dest) : 8'd0;
        e_to  = 64'(cur_move) << (cur_dest * 8);
        c8    = (drops > 255) ? 255 : drops;
        c2    = (drops > 3) ? 3 : drops;
        check("ack", 64'(ack1), 64'(e_ack));
        check("valid", 64'(vld1), 64'(e_vld));
        check("move_to", to1, e_to);
        check("err_bad", 64'(bad1), 64'(m_bad));
        check("err_addr", 64'(eaddr1), 64'(m_eaddr));
        check("drop_cnt8", 64'(cnt1), 64'(c8));
        check("ack2", 64'(ack2), 64'(e_ack));
        check("valid2", 64'(vld2), 64'(e_vld));
        check("move_to2", to2, e_to);
        check("err_bad2", 64'(bad2), 64'(m_bad));
        check("err_addr2", 64'(eaddr2), 64'(m_eaddr));
        check("drop_cnt2", 64'(cnt2), 64'(c2));
        in_x  = vld && e_ack;
        out_x = (q.size() != 0) && oack[q[0].dest];
        @(posedge clk);
        if (out_x) void'(q.pop_front());
        if (in_x && addr < 8) begin
            q.push_back('{addr, mv});
            cur_dest = addr;
            cur_move = mv;
        end
        if (clr) begin
            m_bad   = 0;
            m_eaddr = 0;
            drops   = 0;
        end else if (in_x && addr >= 8) begin
            if (!m_bad) m_eaddr = addr;
            m_bad = 1;
            drops++;
        end
        #1;
    endtask

    task automatic do_reset(input int cycles);
        resetn        = 1'b0;
        in_move_valid = 1'b0;
        err_clear     = 1'b0;
        out_move_ack  = '0;
        repeat (cycles) @(posedge clk);
        model_reset();
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        move_buffer_addr = '0;
        in_move_to       = '0;
        model_reset();
        do_reset(2);

        // Reset state
        #1;
        check("rst_valid", 64'(vld1), 64'd0);
        check("rst_to", to1, 64'd0);
        check("rst_cnt", 64'(cnt1), 64'd0);
        check("rst_ack", 64'(ack1), 64'd1);
        step(0, 0, 0, 8'h00, 0);

        // Streaming to slot 3
        step(3, 'h11, 1, 8'h08, 0);
        step(3, 'h12, 1, 8'h08, 0);
        step(3, 'h13, 1, 8'h08, 0);
        step(3, 0, 0, 8'h08, 0);
        step(0, 0, 0, 8'h00, 0);

        // Backpressure on slot 5
        step(5, 'hA5, 1, 8'h00, 0);
        repeat (4) step(5, 'h5A, 1, 8'h00, 0);
        check("bp_held", to1, 64'hA5 << 40);
        step(5, 'h5A, 0, 8'h20, 0);
        step(0, 0, 0, 8'h00, 0);
        check("bp_empty", 64'(vld1), 64'd0);

        // Address change while stalled; ack on slot 6 must be ignored
        step(2, 'h22, 1, 8'h00, 0);
        step(6, 'h66, 1, 8'h40, 0);
        step(6, 'h66, 1, 8'h00, 0);
        step(6, 'h66, 0, 8'h04, 0);
        step(0, 0, 0, 8'h00, 0);

        // Bad addresses 9 then 12
        step(9, 'h99, 1, 8'h00, 0);
        step(12, 'hCC, 1, 8'h00, 0);
        step(0, 0, 0, 8'h00, 0);
        check("bad_addr9", 64'(eaddr1), 64'd9);
        check("bad_cnt2", 64'(cnt1), 64'd2);
        step(0, 0, 0, 8'h00, 1);
        step(0, 0, 0, 8'h00, 0);

        // Saturation at CNT_W=2, then drop with clear
        repeat (5) step(10, 'h01, 1, 8'h00, 0);
        step(0, 0, 0, 8'h00, 0);
        check("sat_cnt2", 64'(cnt2), 64'd3);
        check("sat_cnt8", 64'(cnt1), 64'd5);
        step(11, 'h02, 1, 8'h00, 1);
        step(0, 0, 0, 8'h00, 0);
        check("clr_drop", 64'(cnt2), 64'd0);

        // Random traffic with occasional clear and reset
        for (int n = 0; n < 600; n++) begin
            int a;
            if (($urandom % 100) == 0) do_reset(1 + ($urandom % 2));
            a = (($urandom % 5) == 0) ? int'($urandom_range(8, 15))
                                       : int'($urandom_range(0, 7));
            step(a, int'($urandom % 256), ($urandom % 4) != 0,
                 8'($urandom), ($urandom % 25) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
